// File: rtl/dmi_core_bridge.sv
// dmi_core_bridge: core-clock stage between the DMI CDC core-side port and the
// debug module CSR block. It carries one transaction at a time, aborts a stuck
// debug module with DTM_ERR after TimeoutCycles, and drains stale responses.
// Optional statistics counters are enabled with `define DMI_BRIDGE_STATS_EN.

package dm;
  localparam logic [1:0] DTM_NOP     = 2'h0;
  localparam logic [1:0] DTM_READ    = 2'h1;
  localparam logic [1:0] DTM_WRITE   = 2'h2;

  localparam logic [1:0] DTM_SUCCESS = 2'h0;
  localparam logic [1:0] DTM_ERR     = 2'h2;
  localparam logic [1:0] DTM_BUSY    = 2'h3;

  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;
endpackage

module dmi_core_bridge #(
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  dm::dmi_req_t  up_req_i,
  input  logic          up_req_valid_i,
  output logic          up_req_ready_o,
  output dm::dmi_resp_t up_resp_o,
  output logic          up_resp_valid_o,
  input  logic          up_resp_ready_i,
  output dm::dmi_req_t  dm_req_o,
  output logic          dm_req_valid_o,
  input  logic          dm_req_ready_i,
  input  dm::dmi_resp_t dm_resp_i,
  input  logic          dm_resp_valid_i,
  output logic          dm_resp_ready_o,
  output logic          busy_o,
  output logic          timeout_o,
  output logic [15:0]   err_cnt_o,
  output logic [15:0]   timeout_cnt_o
);

  localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);
  localparam logic [CntWidth-1:0] CntMax  = CntWidth'(TimeoutCycles);

  typedef enum logic [1:0] {Idle, Issue, Wait, Respond} state_e;

  state_e              state_q, state_d;
  dm::dmi_req_t        req_q, req_d;
  dm::dmi_resp_t       resp_q, resp_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                timeout_q, timeout_d;

  // Next-state, datapath capture and handshake outputs; clear_i overrides everything.
  always_comb begin
    state_d         = state_q;
    req_d           = req_q;
    resp_d          = resp_q;
    cnt_d           = cnt_q;
    timeout_d       = 1'b0;
    up_req_ready_o  = 1'b0;
    dm_req_valid_o  = 1'b0;
    dm_resp_ready_o = 1'b0;
    up_resp_valid_o = 1'b0;

    unique case (state_q)
      Idle: begin
        // Anything arriving from the debug module here is stale and is swallowed.
        up_req_ready_o  = 1'b1;
        dm_resp_ready_o = 1'b1;
        if (up_req_valid_i) begin
          req_d   = up_req_i;
          cnt_d   = '0;
          state_d = Issue;
        end
      end
      Issue: begin
        dm_req_valid_o = 1'b1;
        if (cnt_q != CntMax) cnt_d = cnt_q + CntWidth'(1);
        if (dm_req_ready_i) begin
          state_d = Wait;
        end else if (cnt_q >= CntLast) begin
          resp_d    = '{data: 32'h0, resp: dm::DTM_ERR};
          timeout_d = 1'b1;
          state_d   = Respond;
        end
      end
      Wait: begin
        dm_resp_ready_o = 1'b1;
        if (cnt_q != CntMax) cnt_d = cnt_q + CntWidth'(1);
        if (dm_resp_valid_i) begin
          resp_d  = dm_resp_i;
          state_d = Respond;
        end else if (cnt_q >= CntLast) begin
          resp_d    = '{data: 32'h0, resp: dm::DTM_ERR};
          timeout_d = 1'b1;
          state_d   = Respond;
        end
      end
      Respond: begin
        up_resp_valid_o = 1'b1;
        if (up_resp_ready_i) state_d = Idle;
      end
      default: state_d = Idle;
    endcase

    if (clear_i) begin
      state_d   = Idle;
      req_d     = '0;
      resp_d    = '0;
      cnt_d     = '0;
      timeout_d = 1'b0;
    end
  end

  // State, captured request/response, timeout counter and registered abort pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= Idle;
      req_q     <= '0;
      resp_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      resp_q    <= resp_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign dm_req_o  = req_q;
  assign up_resp_o = resp_q;
  assign busy_o    = (state_q != Idle);
  assign timeout_o = timeout_q;

`ifdef DMI_BRIDGE_STATS_EN
  logic [15:0] err_cnt_q, timeout_cnt_q;
  logic        up_resp_hs;

  assign up_resp_hs = (state_q == Respond) && up_resp_ready_i;

  // Saturating error/timeout statistics, flushed together with the datapath.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q     <= '0;
      timeout_cnt_q <= '0;
    end else if (clear_i) begin
      err_cnt_q     <= '0;
      timeout_cnt_q <= '0;
    end else begin
      if (up_resp_hs && (resp_q.resp == dm::DTM_ERR) && (err_cnt_q != 16'hFFFF))
        err_cnt_q <= err_cnt_q + 16'd1;
      if (timeout_q && (timeout_cnt_q != 16'hFFFF))
        timeout_cnt_q <= timeout_cnt_q + 16'd1;
    end
  end

  assign err_cnt_o     = err_cnt_q;
  assign timeout_cnt_o = timeout_cnt_q;
`else
  assign err_cnt_o     = 16'h0;
  assign timeout_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_dmi_core_bridge.sv
// tb_dmi_core_bridge: directed bench for dmi_core_bridge with TimeoutCycles=8.
// A vector table covers the normal transaction flow; hand-written sequences
// cover timeout, timeout-cycle race, clear_i and the optional statistics.

module tb_dmi_core_bridge;

  localparam int unsigned TO = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          clear_i;
  dm::dmi_req_t  up_req_i;
  logic          up_req_valid_i;
  logic          up_req_ready_o;
  dm::dmi_resp_t up_resp_o;
  logic          up_resp_valid_o;
  logic          up_resp_ready_i;
  dm::dmi_req_t  dm_req_o;
  logic          dm_req_valid_o;
  logic          dm_req_ready_i;
  dm::dmi_resp_t dm_resp_i;
  logic          dm_resp_valid_i;
  logic          dm_resp_ready_o;
  logic          busy_o;
  logic          timeout_o;
  logic [15:0]   err_cnt_o;
  logic [15:0]   timeout_cnt_o;

  dmi_core_bridge #(.TimeoutCycles(TO)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .clear_i         (clear_i),
    .up_req_i        (up_req_i),
    .up_req_valid_i  (up_req_valid_i),
    .up_req_ready_o  (up_req_ready_o),
    .up_resp_o       (up_resp_o),
    .up_resp_valid_o (up_resp_valid_o),
    .up_resp_ready_i (up_resp_ready_i),
    .dm_req_o        (dm_req_o),
    .dm_req_valid_o  (dm_req_valid_o),
    .dm_req_ready_i  (dm_req_ready_i),
    .dm_resp_i       (dm_resp_i),
    .dm_resp_valid_i (dm_resp_valid_i),
    .dm_resp_ready_o (dm_resp_ready_o),
    .busy_o          (busy_o),
    .timeout_o       (timeout_o),
    .err_cnt_o       (err_cnt_o),
    .timeout_cnt_o   (timeout_cnt_o)
  );

  // Free-running core clock, 10 time units per cycle.
  always #5 clk_i = ~clk_i;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} exp_state_e;

  typedef struct packed {
    logic          clr;
    logic          rq_v;
    dm::dmi_req_t  rq;
    logic          dq_rdy;
    logic          ds_v;
    dm::dmi_resp_t ds;
    logic          us_rdy;
    exp_state_e    st;
    dm::dmi_req_t  e_dq;
    dm::dmi_resp_t e_us;
    logic          e_to;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  dm::dmi_req_t  zq, w_req, r_req, b_req, x_req, t_req, n1_req, n2_req;
  dm::dmi_resp_t zs, ok0, rd_ok, busy_rs, err0, late_rs, a5_rs, derr;

  function automatic vec_t mk(input logic clr, input logic rq_v, input dm::dmi_req_t rq,
                              input logic dq_rdy, input logic ds_v, input dm::dmi_resp_t ds,
                              input logic us_rdy, input exp_state_e st,
                              input dm::dmi_req_t e_dq, input dm::dmi_resp_t e_us,
                              input logic e_to);
    vec_t v;
    v.clr = clr;  v.rq_v = rq_v;  v.rq = rq;  v.dq_rdy = dq_rdy;
    v.ds_v = ds_v;  v.ds = ds;  v.us_rdy = us_rdy;  v.st = st;
    v.e_dq = e_dq;  v.e_us = e_us;  v.e_to = e_to;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_stimulus(input vec_t v);
    clear_i         = v.clr;
    up_req_valid_i  = v.rq_v;
    up_req_i        = v.rq;
    dm_req_ready_i  = v.dq_rdy;
    dm_resp_valid_i = v.ds_v;
    dm_resp_i       = v.ds;
    up_resp_ready_i = v.us_rdy;
  endtask

  task automatic idle_inputs();
    apply_stimulus(mk(0, 0, zq, 0, 0, zs, 0, S_IDLE, zq, zs, 0));
  endtask

  // Expected handshake flags come from the state the bridge should be in;
  // payloads are compared only while their valid is expected high.
  task automatic check_output(input string name, input exp_state_e st,
                              input dm::dmi_req_t e_dq, input dm::dmi_resp_t e_us,
                              input logic e_to);
    logic [4:0]    ef;
    logic [80:0]   act, expv;
    dm::dmi_req_t  xdq, adq;
    dm::dmi_resp_t xus, aus;
    case (st)
      S_IDLE:  ef = 5'b10100;
      S_ISSUE: ef = 5'b01001;
      S_WAIT:  ef = 5'b00101;
      default: ef = 5'b00011;
    endcase
    xdq = ef[3] ? e_dq : zq;
    adq = ef[3] ? dm_req_o : zq;
    xus = ef[1] ? e_us : zs;
    aus = ef[1] ? up_resp_o : zs;
    expv = {ef, e_to, xdq, xus};
    act  = {up_req_ready_o, dm_req_valid_o, dm_resp_ready_o, up_resp_valid_o,
            busy_o, timeout_o, adq, aus};
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic check_value(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic do_timeout_txn();
    up_req_valid_i = 1'b1; up_req_i = t_req; tick(); up_req_valid_i = 1'b0;
    repeat (TO) tick();
    up_resp_ready_i = 1'b1; tick(); up_resp_ready_i = 1'b0;
  endtask

  task automatic do_err_txn();
    up_req_valid_i = 1'b1; up_req_i = x_req; tick(); up_req_valid_i = 1'b0;
    dm_req_ready_i = 1'b1; tick(); dm_req_ready_i = 1'b0;
    dm_resp_valid_i = 1'b1; dm_resp_i = derr; tick(); dm_resp_valid_i = 1'b0;
    up_resp_ready_i = 1'b1; tick(); up_resp_ready_i = 1'b0;
  endtask

  // Safety net so the run always ends even if the sequence stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence.
  initial begin
    logic [112:0] rst_act;
    zq      = '0;
    zs      = '0;
    w_req   = '{addr: 7'h10, op: dm::DTM_WRITE, data: 32'hCAFE_F00D};
    r_req   = '{addr: 7'h11, op: dm::DTM_READ,  data: 32'h0};
    b_req   = '{addr: 7'h04, op: dm::DTM_READ,  data: 32'h0};
    x_req   = '{addr: 7'h16, op: dm::DTM_WRITE, data: 32'h0000_0BAD};
    t_req   = '{addr: 7'h38, op: dm::DTM_READ,  data: 32'h0};
    n1_req  = '{addr: 7'h20, op: dm::DTM_WRITE, data: 32'h1111_2222};
    n2_req  = '{addr: 7'h21, op: dm::DTM_WRITE, data: 32'h3333_4444};
    ok0     = '{data: 32'h0,         resp: dm::DTM_SUCCESS};
    rd_ok   = '{data: 32'h1234_5678, resp: dm::DTM_SUCCESS};
    busy_rs = '{data: 32'hFFFF_0001, resp: dm::DTM_BUSY};
    err0    = '{data: 32'h0,         resp: dm::DTM_ERR};
    late_rs = '{data: 32'hDEAD_BEEF, resp: dm::DTM_SUCCESS};
    a5_rs   = '{data: 32'hA5A5_A5A5, resp: dm::DTM_SUCCESS};
    derr    = '{data: 32'h0000_00E1, resp: dm::DTM_ERR};
    idle_inputs();

    // Reset values: only the two ready outputs are high.
    #12;
    rst_act = {up_req_ready_o, dm_req_valid_o, dm_resp_ready_o, up_resp_valid_o, busy_o,
               timeout_o, dm_req_o, up_resp_o, err_cnt_o, timeout_cnt_o};
    checks++;
    if (rst_act !== {5'b10100, 1'b0, 41'h0, 34'h0, 32'h0}) begin
      errors++;
      $display("[TB] FAIL reset: got %h expected %h", rst_act,
               {5'b10100, 1'b0, 41'h0, 34'h0, 32'h0});
    end
    @(negedge clk_i) rst_ni = 1'b1;
    tick();

    // Write (ready after 2 cycles, response 1 cycle later), read with a held-off
    // upstream consumer while another request waits, then a BUSY pass-through.
    tbl.push_back(mk(0, 1, w_req, 0, 0, zs,      0, S_IDLE,  zq,    zs, 0));
    tbl.push_back(mk(0, 0, zq,    0, 0, zs,      0, S_ISSUE, w_req, zs, 0));
    tbl.push_back(mk(0, 0, zq,    1, 0, zs,      0, S_ISSUE, w_req, zs, 0));
    tbl.push_back(mk(0, 0, zq,    0, 0, zs,      0, S_WAIT,  zq,    zs, 0));
    tbl.push_back(mk(0, 0, zq,    0, 1, ok0,     0, S_WAIT,  zq,    zs, 0));
    tbl.push_back(mk(0, 0, zq,    0, 0, zs,      1, S_RESP,  zq,    ok0, 0));
    tbl.push_back(mk(0, 1, r_req, 0, 0, zs,      0, S_IDLE,  zq,    zs, 0));
    tbl.push_back(mk(0, 0, zq,    1, 0, zs,      0, S_ISSUE, r_req, zs, 0));
    tbl.push_back(mk(0, 0, zq,    0, 1, rd_ok,   0, S_WAIT,  zq,    zs, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 1, b_req, 0, 0, zs,    0, S_RESP,  zq,    rd_ok, 0));
    tbl.push_back(mk(0, 0, zq,    0, 0, zs,      1, S_RESP,  zq,    rd_ok, 0));
    tbl.push_back(mk(0, 1, b_req, 0, 0, zs,      0, S_IDLE,  zq,    zs, 0));
    tbl.push_back(mk(0, 0, zq,    1, 0, zs,      0, S_ISSUE, b_req, zs, 0));
    tbl.push_back(mk(0, 0, zq,    0, 1, busy_rs, 0, S_WAIT,  zq,    zs, 0));
    tbl.push_back(mk(0, 0, zq,    0, 0, zs,      1, S_RESP,  zq,    busy_rs, 0));
    tbl.push_back(mk(0, 0, zq,    0, 0, zs,      0, S_IDLE,  zq,    zs, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      check_output($sformatf("vec%0d", i), tbl[i].st, tbl[i].e_dq, tbl[i].e_us, tbl[i].e_to);
      apply_stimulus(tbl[i]);
      tick();
    end
    idle_inputs();

    // Timeout in Issue: eight cycles without a handshake, then DTM_ERR.
    up_req_valid_i = 1'b1; up_req_i = t_req; tick(); up_req_valid_i = 1'b0;
    for (int i = 0; i < TO; i++) begin
      check_output($sformatf("to_issue%0d", i), S_ISSUE, t_req, zs, 1'b0);
      tick();
    end
    check_output("to_abort", S_RESP, zq, err0, 1'b1);
    up_resp_ready_i = 1'b1; tick(); up_resp_ready_i = 1'b0;
    check_output("to_done", S_IDLE, zq, zs, 1'b0);
    tick(); tick();
    dm_resp_valid_i = 1'b1; dm_resp_i = late_rs;
    check_output("late_drain", S_IDLE, zq, zs, 1'b0);
    tick();
    dm_resp_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_output($sformatf("late_drop%0d", i), S_IDLE, zq, zs, 1'b0);
      tick();
    end

    // Response lands exactly in the last budget cycle: it must win over the abort.
    up_req_valid_i = 1'b1; up_req_i = r_req; tick(); up_req_valid_i = 1'b0;
    dm_req_ready_i = 1'b1;
    check_output("race_issue", S_ISSUE, r_req, zs, 1'b0);
    tick(); dm_req_ready_i = 1'b0;
    for (int i = 1; i < TO - 1; i++) begin
      check_output($sformatf("race_wait%0d", i), S_WAIT, zq, zs, 1'b0);
      tick();
    end
    dm_resp_valid_i = 1'b1; dm_resp_i = a5_rs;
    check_output("race_last", S_WAIT, zq, zs, 1'b0);
    tick(); dm_resp_valid_i = 1'b0;
    check_output("race_resp", S_RESP, zq, a5_rs, 1'b0);
    up_resp_ready_i = 1'b1; tick(); up_resp_ready_i = 1'b0;
    check_output("race_done", S_IDLE, zq, zs, 1'b0);

    // clear_i during Wait drops the transaction; clear wins over a new request.
    up_req_valid_i = 1'b1; up_req_i = w_req; tick(); up_req_valid_i = 1'b0;
    dm_req_ready_i = 1'b1; tick(); dm_req_ready_i = 1'b0;
    check_output("clr_wait", S_WAIT, zq, zs, 1'b0);
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    check_output("clr_idle", S_IDLE, zq, zs, 1'b0);
    clear_i = 1'b1; up_req_valid_i = 1'b1; up_req_i = n1_req; tick();
    clear_i = 1'b0; up_req_i = n2_req;
    check_output("clr_noaccept", S_IDLE, zq, zs, 1'b0);
    tick(); up_req_valid_i = 1'b0;
    check_output("clr_newreq", S_ISSUE, n2_req, zs, 1'b0);
    dm_req_ready_i = 1'b1; tick(); dm_req_ready_i = 1'b0;
    dm_resp_valid_i = 1'b1; dm_resp_i = ok0; tick(); dm_resp_valid_i = 1'b0;
    check_output("clr_resp", S_RESP, zq, ok0, 1'b0);
    up_resp_ready_i = 1'b1; tick(); up_resp_ready_i = 1'b0;

    // Statistics: 3 timeouts and 2 error responses from the debug module.
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    check_value("stats_zero_err", err_cnt_o, 16'd0);
    check_value("stats_zero_to", timeout_cnt_o, 16'd0);
    repeat (3) do_timeout_txn();
    repeat (2) do_err_txn();
`ifdef DMI_BRIDGE_STATS_EN
    check_value("stats_err", err_cnt_o, 16'd5);
    check_value("stats_to", timeout_cnt_o, 16'd3);
`else
    check_value("stats_err", err_cnt_o, 16'd0);
    check_value("stats_to", timeout_cnt_o, 16'd0);
`endif
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    check_value("stats_clr_err", err_cnt_o, 16'd0);
    check_value("stats_clr_to", timeout_cnt_o, 16'd0);
    check_output("final_idle", S_IDLE, zq, zs, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmi_core_bridge.md
Name: dmi_core_bridge

Overview:
- Core-clock (clk_i) stage between the DMI CDC core-side port and the debug module CSR block.
- Registers each DMI request, issues it to the debug module, and waits for the response. Returns the response upstream.
- Enforces one outstanding transaction, a response timeout, and dropping of stale responses, so a hung or slow debug module can never wedge the JTAG-side DMI FSM.

Parameters:
TimeoutCycles, 1024, cycles in Issue+Wait before the transaction is aborted with DTM_ERR; legal range >= 2
CntWidth, $clog2(TimeoutCycles+1), timeout counter width (derived, not overridable)

Ports:
clk_i  in  1  core clock
rst_ni  in  1  async active-low reset
clear_i  in  1  synchronous flush (DMI hard reset / ndmreset domain clear)
up_req_i  in  dm::dmi_req_t  request from CDC {addr[6:0], op[1:0], data[31:0]}
up_req_valid_i  in  1  request valid
up_req_ready_o  out  1  request accepted
up_resp_o  out  dm::dmi_resp_t  response to CDC {data[31:0], resp[1:0]}
up_resp_valid_o  out  1  response valid
up_resp_ready_i  in  1  response consumed
dm_req_o  out  dm::dmi_req_t  request to debug module
dm_req_valid_o  out  1  request valid
dm_req_ready_i  in  1  debug module accepts request
dm_resp_i  in  dm::dmi_resp_t  debug module response
dm_resp_valid_i  in  1  response valid
dm_resp_ready_o  out  1  response consumed/drained
busy_o  out  1  state != Idle
timeout_o  out  1  single-cycle pulse on timeout abort
err_cnt_o  out  16  error-response count (optional feature)
timeout_cnt_o  out  16  timeout count (optional feature)

Behaviour:
Clock and reset:
- Clock is clk_i. Reset rst_ni is asynchronous, active-low.
- Reset state: Idle, request/response registers 0, counter 0.
- Reset output values: up_req_ready_o=1, dm_resp_ready_o=1, and every other output 0.

FSM states: Idle, Issue, Wait, Respond.

Idle:
- up_req_ready_o=1 and dm_resp_ready_o=1. Any dm_resp_valid_i seen here is stale; it is drained and discarded.
- On up_req_valid_i, latch up_req_i into req_q, clear the counter, and go to Issue.

Issue:
- dm_req_valid_o=1 with dm_req_o=req_q, held stable. up_req_ready_o=0.
- On dm_req_ready_i, go to Wait. The earliest downstream valid is 1 cycle after upstream acceptance.

Wait:
- dm_resp_ready_o=1. On dm_resp_valid_i, latch dm_resp_i into resp_q and go to Respond.
- dm_resp_ready_o=0 in Issue and Respond.

Respond:
- up_resp_valid_o=1 with up_resp_o=resp_q, held stable until up_resp_ready_i. Then go to Idle.
- The next request is accepted no earlier than the following cycle. Minimum 4 cycles per transaction.

Timeout:
- The counter increments every cycle in Issue and Wait.
- When counter == TimeoutCycles-1 and no completing handshake occurs that cycle: resp_q={32'h0, DTM_ERR}, pulse timeout_o, go to Respond.
- An abort in Issue deliberately drops dm_req_valid_o without a handshake.
- If dm_req_ready_i (Issue) or dm_resp_valid_i (Wait) arrives in the timeout cycle, the real handshake wins and no timeout occurs.

Late responses: a response arriving after a timeout is drained in Idle and never forwarded.

clear_i:
- Synchronous, highest priority over every transition. Next cycle: state Idle, valids low, counter 0, req_q/resp_q 0.
- An in-flight transaction is dropped with no upstream response.
- clear_i and up_req_valid_i in the same cycle: the request is not accepted.

Pass-through and ordering: resp codes pass through unmodified (DTM_SUCCESS=0, DTM_ERR=2, DTM_BUSY=3). No reordering; strictly one outstanding transaction.

Optional Feature:
Macro DMI_BRIDGE_STATS_EN.
- Defined:
  - err_cnt_o increments on every upstream response handshake with resp==DTM_ERR, including timeouts.
  - timeout_cnt_o increments on each timeout_o pulse.
  - Both counters are 16-bit saturating at 16'hFFFF, reset to 0, and cleared by clear_i.
- Not defined: both ports tied to 0 and no counter flops are instantiated.

Test Plan:
- Write addr 7'h10 data 32'hCAFE_F00D, dm ready after 2 cycles, resp SUCCESS after 1 -> dm_req_o matches; up_resp {32'h0 or DM data, 2'h0}; busy_o low after up handshake.
- Read addr 7'h11, DM returns {32'h1234_5678, SUCCESS}, up_resp_ready_i held low 5 cycles -> up_resp_o stable 32'h1234_5678 throughout; up_req_ready_o=0 until delivered.
- TimeoutCycles=8, dm_req_ready_i never asserted -> timeout_o pulses exactly 8 cycles after Issue entry; up_resp {0, DTM_ERR}; a DM response arriving 3 cycles later is drained and never forwarded.
- dm_resp_valid_i asserted exactly in the timeout cycle with data 32'hA5A5_A5A5 -> real response forwarded; timeout_o stays 0.
- clear_i pulsed in Wait -> Idle next cycle, no up_resp_valid_o, busy_o=0; a new request is accepted the following cycle.
- With DMI_BRIDGE_STATS_EN: 3 timeouts + 2 DM DTM_ERR responses -> timeout_cnt_o=3, err_cnt_o=5. clear_i -> both 0. Without the macro -> both read 0.
